// File: rtl/fma_rr_scheduler_if.sv
// fma_rr_scheduler_if
//   Bundles every non-clock/reset signal of the FMA round-robin scheduler.
//   slave  : scheduler view (drives grants, FMA operands, responses, status)
//   master : environment view (requesters plus the FMA pipeline itself)
//   Signals:
//     req_valid/req_a/req_b/req_c  per-requester ops, requester i at [i*WIDTH +: WIDTH]
//     req_ready                    one-hot grant
//     hold                         suppress issue this cycle
//     fma_a/b/c, fma_in_valid      registered issue towards the FMA
//     fma_d, fma_out_valid         FMA result and strobe
//     rsp_valid, rsp_d             one-hot response pulse and shared result bus
//     idle, tag_err, issue_cnt     status
interface fma_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ*WIDTH-1:0] req_c;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     hold;
   logic [WIDTH-1:0]         fma_a;
   logic [WIDTH-1:0]         fma_b;
   logic [WIDTH-1:0]         fma_c;
   logic                     fma_in_valid;
   logic [WIDTH-1:0]         fma_d;
   logic                     fma_out_valid;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]         rsp_d;
   logic                     idle;
   logic                     tag_err;
   logic [31:0]              issue_cnt;

   modport slave (
      input  req_valid, req_a, req_b, req_c, hold, fma_d, fma_out_valid,
      output req_ready, fma_a, fma_b, fma_c, fma_in_valid, rsp_valid, rsp_d,
             idle, tag_err, issue_cnt
   );

   modport master (
      output req_valid, req_a, req_b, req_c, hold, fma_d, fma_out_valid,
      input  req_ready, fma_a, fma_b, fma_c, fma_in_valid, rsp_valid, rsp_d,
             idle, tag_err, issue_cnt
   );
endinterface

// File: rtl/fma_rr_scheduler.sv
// fma_rr_scheduler
//   Shares one fixed-latency FP16 FMA pipeline (no backpressure) among NUM_REQ
//   requesters. A round-robin arbiter issues at most one op per cycle, the
//   requester index rides a LATENCY-deep tag line alongside the FMA, and each
//   result is routed back as a one-hot rsp_valid pulse. Data passes bit-exact.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    fma_rr_scheduler_if.slave (requests, FMA issue/return, responses, status)
module fma_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset,
   fma_rr_scheduler_if.slave bus
);
   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] eligible;
   logic               grant_vld;
   logic [TAG_W-1:0]   grant_idx;
   logic [TAG_W-1:0]   scan_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic [TAG_W-1:0]   rr_ptr;

   logic [WIDTH-1:0]   op_a [NUM_REQ];
   logic [WIDTH-1:0]   op_b [NUM_REQ];
   logic [WIDTH-1:0]   op_c [NUM_REQ];

   logic [WIDTH-1:0]   fma_a_p0;
   logic [WIDTH-1:0]   fma_b_p0;
   logic [WIDTH-1:0]   fma_c_p0;
   logic [TAG_W-1:0]   tag_p0;
   logic               vld_p0;
   logic [31:0]        issue_cnt_q;

   logic [LATENCY-1:0] line_v;
   logic [TAG_W-1:0]   line_tag [LATENCY];
   logic               tail_v;
   logic [NUM_REQ-1:0] tail_oh;

   logic [NUM_REQ-1:0] rsp_vld_p1;
   logic [WIDTH-1:0]   rsp_d_p1;
   logic               tag_err_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_a[i] = bus.req_a[i*WIDTH +: WIDTH];
      assign op_b[i] = bus.req_b[i*WIDTH +: WIDTH];
      assign op_c[i] = bus.req_c[i*WIDTH +: WIDTH];
   end

   // Arbitration: scan from the requester after the last winner; hold masks
   // every request so the grant drops in the same cycle.
   always_comb begin
      eligible  = bus.req_valid & {NUM_REQ{~bus.hold}};
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      grant_oh  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!grant_vld && eligible[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = grant_vld && (grant_idx == TAG_W'(i));
      end
   end

   // Stage p0: issue register towards the FMA
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fma_a_p0    <= '0;
         fma_b_p0    <= '0;
         fma_c_p0    <= '0;
         tag_p0      <= '0;
         vld_p0      <= 1'b0;
         rr_ptr      <= TAG_W'(NUM_REQ - 1);
         issue_cnt_q <= '0;
      end else begin
         vld_p0 <= grant_vld;
         if (grant_vld) begin
            fma_a_p0    <= op_a[grant_idx];
            fma_b_p0    <= op_b[grant_idx];
            fma_c_p0    <= op_c[grant_idx];
            tag_p0      <= grant_idx;
            rr_ptr      <= grant_idx;
            issue_cnt_q <= issue_cnt_q + 32'd1;
         end
      end
   end

   // Tag line: shadows the FMA pipeline so the tail lines up with fma_out_valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_v <= '0;
         for (int i = 0; i < LATENCY; i++) line_tag[i] <= '0;
      end else begin
         line_v[0]   <= vld_p0;
         line_tag[0] <= tag_p0;
         for (int i = 1; i < LATENCY; i++) begin
            line_v[i]   <= line_v[i-1];
            line_tag[i] <= line_tag[i-1];
         end
      end
   end

   always_comb begin
      tail_v  = line_v[LATENCY-1];
      tail_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         tail_oh[i] = (line_tag[LATENCY-1] == TAG_W'(i));
      end
   end

   // Stage p1: response register; a strobe without a tail entry (or the
   // reverse) is a misalignment and latches tag_err
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_vld_p1 <= '0;
         rsp_d_p1   <= '0;
         tag_err_q  <= 1'b0;
      end else begin
         rsp_vld_p1 <= '0;
         if (bus.fma_out_valid && tail_v) begin
            rsp_vld_p1 <= tail_oh;
            rsp_d_p1   <= bus.fma_d;
         end
         if (bus.fma_out_valid != tail_v) tag_err_q <= 1'b1;
      end
   end

   assign bus.req_ready    = grant_oh;
   assign bus.fma_a        = fma_a_p0;
   assign bus.fma_b        = fma_b_p0;
   assign bus.fma_c        = fma_c_p0;
   assign bus.fma_in_valid = vld_p0;
   assign bus.rsp_valid    = rsp_vld_p1;
   assign bus.rsp_d        = rsp_d_p1;
   assign bus.tag_err      = tag_err_q;
   assign bus.issue_cnt    = issue_cnt_q;
   assign bus.idle         = ~vld_p0 & ~(|line_v) & ~(|rsp_vld_p1);
endmodule

// File: tb/tb_fma_rr_scheduler.sv
// tb_fma_rr_scheduler
//   Directed bench for fma_rr_scheduler (NUM_REQ=4, WIDTH=16, LATENCY=3).
//   Includes a behavioural 3-stage FP16 FMA with fault-injection controls.
module tb_fma_rr_scheduler;
   localparam int NR  = 4;
   localparam int W   = 16;
   localparam int LAT = 3;

   logic clk;
   logic reset;
   logic spur;
   logic suppress;
   int   checks = 0;
   int   errors = 0;

   fma_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus_if ();

   fma_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // FP16 helpers for the FMA model (normal numbers only)
   function automatic real pow2(input int e);
      real r;
      r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      real v;
      int  e;
      e = int'(h[14:10]);
      if (e == 0) v = (real'(h[9:0]) / 1024.0) * pow2(-14);
      else        v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real x);
      real         v;
      int          e;
      int          m;
      logic        s;
      logic [31:0] ev;
      logic [31:0] mv;
      if (x == 0.0) return 16'h0000;
      s = (x < 0.0);
      v = s ? -x : x;
      e = 15;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      m  = int'((v - 1.0) * 1024.0);
      ev = 32'(e);
      mv = 32'(m);
      return {s, ev[4:0], mv[9:0]};
   endfunction

   // Behavioural FMA: LAT register stages, shares the scheduler reset
   logic [LAT-1:0] pipe_v;
   logic [15:0]    pipe_d [LAT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v <= '0;
      end else begin
         pipe_v    <= {pipe_v[LAT-2:0], bus_if.fma_in_valid};
         pipe_d[0] <= r2h(h2r(bus_if.fma_a) * h2r(bus_if.fma_b) + h2r(bus_if.fma_c));
         for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
      end
   end

   assign bus_if.fma_out_valid = (pipe_v[LAT-1] && !suppress) || spur;
   assign bus_if.fma_d         = pipe_d[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      bus_if.req_a[i*W +: W] = a;
      bus_if.req_b[i*W +: W] = b;
      bus_if.req_c[i*W +: W] = c;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus_if.req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   // Hand-encoded FP16 constants
   logic [15:0] aval   [4]  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};      // 1,2,3,4
   logic [15:0] t2_b   [3]  = '{16'h4000, 16'h4200, 16'h4400};                // 2,3,4
   logic [15:0] t2_c   [3]  = '{16'h3C00, 16'h4000, 16'h3800};                // 1,2,0.5
   logic [15:0] t2_exp [12] = '{16'h4200, 16'h4500, 16'h4700, 16'h4880,       // 3,5,7,9
                                16'h4500, 16'h4800, 16'h4980, 16'h4B00,       // 5,8,11,14
                                16'h4480, 16'h4840, 16'h4A40, 16'h4C20};      // 4.5,8.5,12.5,16.5
   logic [15:0] t4_a   [3]  = '{16'h3C00, 16'h4000, 16'h4200};                // 1,2,3

   initial begin
      reset            = 1'b1;
      spur             = 1'b0;
      suppress         = 1'b0;
      bus_if.hold      = 1'b0;
      bus_if.req_valid = '0;
      bus_if.req_a     = '0;
      bus_if.req_b     = '0;
      bus_if.req_c     = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_valid", 32'(bus_if.fma_in_valid), 32'd0);
      check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst_rsp_d", 32'(bus_if.rsp_d), 32'd0);
      check("rst_fma_a", 32'(bus_if.fma_a), 32'd0);
      check("rst_idle", 32'(bus_if.idle), 32'd1);
      check("rst_tag_err", 32'(bus_if.tag_err), 32'd0);
      check("rst_issue_cnt", bus_if.issue_cnt, 32'd0);
      check("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
      reset = 1'b0;

      // Single op: 1*2+1 = 3
      @(negedge clk);
      set_op(0, 16'h3C00, 16'h4000, 16'h3C00);
      bus_if.req_valid = 4'b0001;
      #1 check("t1_ready", 32'(bus_if.req_ready), 32'h1);
      @(negedge clk);
      check("t1_in_valid", 32'(bus_if.fma_in_valid), 32'd1);
      check("t1_fma_a", 32'(bus_if.fma_a), 32'h3C00);
      check("t1_fma_b", 32'(bus_if.fma_b), 32'h4000);
      check("t1_fma_c", 32'(bus_if.fma_c), 32'h3C00);
      check("t1_busy", 32'(bus_if.idle), 32'd0);
      bus_if.req_valid = '0;
      @(negedge clk);
      check("t1_in_valid_drop", 32'(bus_if.fma_in_valid), 32'd0);
      check("t1_fma_a_hold", 32'(bus_if.fma_a), 32'h3C00);
      check("t1_no_rsp_c2", 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_no_rsp_c3", 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_no_rsp_c4", 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
      check("t1_rsp_d", 32'(bus_if.rsp_d), 32'h4200);
      check("t1_issue_cnt", bus_if.issue_cnt, 32'd1);
      @(negedge clk);
      check("t1_rsp_pulse", 32'(bus_if.rsp_valid), 32'd0);
      check("t1_idle", 32'(bus_if.idle), 32'd1);

      // All four requesters for 12 cycles
      do_reset();
      for (int t = 0; t < 18; t++) begin
         @(negedge clk);
         if (t >= 1 && t <= 12) begin
            check("t2_in_valid", 32'(bus_if.fma_in_valid), 32'd1);
            check("t2_fma_a", 32'(bus_if.fma_a), 32'(aval[(t-1)%4]));
         end
         if (t >= 5 && t <= 16) begin
            check("t2_rsp_valid", 32'(bus_if.rsp_valid), 32'(oh((t-5)%4)));
            check("t2_rsp_d", 32'(bus_if.rsp_d), 32'(t2_exp[t-5]));
         end else begin
            check("t2_rsp_quiet", 32'(bus_if.rsp_valid), 32'd0);
         end
         if (t < 12) begin
            for (int i = 0; i < 4; i++) set_op(i, aval[i], t2_b[t/4], t2_c[t/4]);
            bus_if.req_valid = 4'b1111;
         end else begin
            bus_if.req_valid = '0;
         end
         #1 check("t2_ready", 32'(bus_if.req_ready), (t < 12) ? 32'(oh(t%4)) : 32'd0);
      end
      check("t2_idle", 32'(bus_if.idle), 32'd1);
      check("t2_issue_cnt", bus_if.issue_cnt, 32'd12);

      // Requesters 2 and 3 only, hold every third cycle: 2*3+1 = 7, 3*3+1 = 10
      set_op(2, 16'h4000, 16'h4200, 16'h3C00);
      set_op(3, 16'h4200, 16'h4200, 16'h3C00);
      for (int t = 0; t < 14; t++) begin
         logic [3:0] exp_rsp;
         logic [3:0] exp_rdy;
         @(negedge clk);
         exp_rsp = 4'b0000;
         if (t == 5 || t == 8 || t == 11) exp_rsp = 4'b0100;
         if (t == 6 || t == 9 || t == 12) exp_rsp = 4'b1000;
         check("t3_rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_rsp));
         if (exp_rsp == 4'b0100) check("t3_rsp_d2", 32'(bus_if.rsp_d), 32'h4700);
         if (exp_rsp == 4'b1000) check("t3_rsp_d3", 32'(bus_if.rsp_d), 32'h4900);
         bus_if.req_valid = (t < 9) ? 4'b1100 : 4'b0000;
         bus_if.hold      = (t < 9) && (t % 3 == 2);
         exp_rdy = 4'b0000;
         if (t < 9 && t % 3 == 0) exp_rdy = 4'b0100;
         if (t < 9 && t % 3 == 1) exp_rdy = 4'b1000;
         #1 check("t3_ready", 32'(bus_if.req_ready), 32'(exp_rdy));
      end
      bus_if.hold = 1'b0;
      check("t3_issue_cnt", bus_if.issue_cnt, 32'd18);

      // Spurious FMA strobe with an empty tag line
      check("t4_err_clear", 32'(bus_if.tag_err), 32'd0);
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      check("t4_spur_err", 32'(bus_if.tag_err), 32'd1);
      check("t4_spur_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      @(negedge clk);
      check("t4_spur_sticky", 32'(bus_if.tag_err), 32'd1);
      check("t4_spur_no_rsp2", 32'(bus_if.rsp_valid), 32'd0);

      // Suppressed real strobe: ops 1+1=2, 2+1=3 (dropped), 3+1=4
      do_reset();
      check("t4_err_reset", 32'(bus_if.tag_err), 32'd0);
      for (int t = 0; t < 9; t++) begin
         @(negedge clk);
         if (t == 5 || t == 7) check("t4_rsp_valid", 32'(bus_if.rsp_valid), 32'h1);
         else                  check("t4_rsp_quiet", 32'(bus_if.rsp_valid), 32'd0);
         if (t == 5 || t == 6) check("t4_rsp_d_op0", 32'(bus_if.rsp_d), 32'h4000);
         if (t == 7)           check("t4_rsp_d_op2", 32'(bus_if.rsp_d), 32'h4400);
         if (t <= 5)           check("t4_err_before", 32'(bus_if.tag_err), 32'd0);
         if (t >= 6)           check("t4_err_after", 32'(bus_if.tag_err), 32'd1);
         if (t < 3) set_op(0, t4_a[t], 16'h3C00, 16'h3C00);
         bus_if.req_valid = (t < 3) ? 4'b0001 : 4'b0000;
         suppress = (t == 5);
      end
      check("t4_idle", 32'(bus_if.idle), 32'd1);

      // Reset with three ops in flight
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, aval[i], 16'h4000, 16'h3C00);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         bus_if.req_valid = 4'b1111;
      end
      @(negedge clk);
      check("t5_busy", 32'(bus_if.idle), 32'd0);
      reset = 1'b1;
      #1;
      check("t5_in_valid", 32'(bus_if.fma_in_valid), 32'd0);
      check("t5_fma_a", 32'(bus_if.fma_a), 32'd0);
      check("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("t5_idle", 32'(bus_if.idle), 32'd1);
      check("t5_issue_cnt", bus_if.issue_cnt, 32'd0);
      check("t5_first_grant", 32'(bus_if.req_ready), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      bus_if.req_valid = '0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
         check("t5_no_err", 32'(bus_if.tag_err), 32'd0);
      end
      bus_if.req_valid = 4'b1111;
      #1 check("t5_post_grant", 32'(bus_if.req_ready), 32'h1);
      @(negedge clk);
      bus_if.req_valid = '0;
      check("t5_post_issue", 32'(bus_if.fma_in_valid), 32'd1);
      check("t5_post_fma_a", 32'(bus_if.fma_a), 32'h3C00);
      repeat (6) @(negedge clk);

      // Issue counter wrap
      force dut.issue_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.issue_cnt_q;
      check("t6_preset", bus_if.issue_cnt, 32'hFFFF_FFFF);
      bus_if.req_valid = 4'b0001;
      @(negedge clk);
      bus_if.req_valid = '0;
      check("t6_wrap", bus_if.issue_cnt, 32'd0);
      repeat (6) @(negedge clk);
      check("t6_idle", 32'(bus_if.idle), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
